// File: rtl/ppu_pkg.sv
// ppu_pkg: shared FSM encoding, PPU base addresses and attribute-table address helpers
package ppu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NT,
    S_AT,
    S_PLO,
    S_PHI,
    S_OUT
  } state_t;

  localparam logic [13:0] AT_BASE = 14'h23C0;
  localparam logic [15:0] NT_BASE = 16'h2000;

  // Attribute byte covering the 4x4-tile block that holds this nametable entry.
  function automatic logic [13:0] attr_addr(input logic [13:0] ptr);
    return AT_BASE | (ptr & 14'h0C00) | ((ptr >> 4) & 14'h0038) | ((ptr >> 2) & 14'h0007);
  endfunction

  // Two-bit palette select for the 2x2-tile quadrant {ptr[6], ptr[1]}.
  function automatic logic [1:0] attr_sel(input logic [13:0] ptr, input logic [7:0] at);
    return at[{ptr[6], ptr[1], 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/ppu_attr_addr.sv
// ppu_attr_addr: combinational attribute-table address and quadrant palette select
module ppu_attr_addr
  import ppu_pkg::*;
(
  input  logic [13:0] ptr_i,
  input  logic [7:0]  at_byte_i,
  output logic [13:0] addr_o,
  output logic [1:0]  attr_o
);

  logic unused;

  assign addr_o = attr_addr(ptr_i);
  assign attr_o = attr_sel(ptr_i, at_byte_i);
  assign unused = ^{ptr_i[13:12], ptr_i[5], ptr_i[0]};

endmodule

// File: rtl/ppu_bg_tile_fetcher.sv
// ppu_bg_tile_fetcher: fetches one background tile (name, attribute, two pattern planes); PPU_BGF_ATTR_EN enables the attribute fetch
module ppu_bg_tile_fetcher
  import ppu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_start,
  output logic        fetch_ready,
  input  logic [15:0] nametable_ptr,
  input  logic [2:0]  pattern_table_offset,
  input  logic [7:0]  ppu_ctrl1,
  output logic [13:0] vram_addr,
  output logic        vram_rd,
  input  logic        vram_ack,
  input  logic [7:0]  vram_data,
  output logic        tile_valid,
  input  logic        tile_ready,
  output logic [7:0]  tile_pattern_lo,
  output logic [7:0]  tile_pattern_hi,
  output logic [1:0]  tile_attr
);

  state_t      state_q, state_d;
  logic [13:0] ptr_q, ptr_d;
  logic [2:0]  off_q, off_d;
  logic        sel_q, sel_d;
  logic [7:0]  idx_q, idx_d;
  logic [1:0]  attr_q, attr_d;
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  hi_q, hi_d;
  logic [13:0] at_addr;
  logic [1:0]  at_sel;
  logic [13:0] pat_addr;
  state_t      nt_next;
  logic        unused;

`ifdef PPU_BGF_ATTR_EN
  ppu_attr_addr u_attr (
    .ptr_i     (ptr_q),
    .at_byte_i (vram_data),
    .addr_o    (at_addr),
    .attr_o    (at_sel)
  );
  assign nt_next = S_AT;
`else
  assign at_addr = '0;
  assign at_sel  = '0;
  assign nt_next = S_PLO;
`endif

  assign pat_addr = {1'b0, sel_q, idx_q, state_q == S_PHI, off_q};
  assign unused   = ^{nametable_ptr[15:14], ppu_ctrl1[7:5], ppu_ctrl1[3:0]};

  // Next-state, latched request fields and read-port drive.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    off_d       = off_q;
    sel_d       = sel_q;
    idx_d       = idx_q;
    attr_d      = attr_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    fetch_ready = state_q == S_IDLE;
    tile_valid  = state_q == S_OUT;
    vram_rd     = state_q inside {S_NT, S_AT, S_PLO, S_PHI};
    vram_addr   = state_q == S_NT ? ptr_q :
                  state_q == S_AT ? at_addr :
                  state_q inside {S_PLO, S_PHI} ? pat_addr : '0;
    case (state_q)
      S_IDLE: if (fetch_start) begin
        ptr_d   = nametable_ptr[13:0];
        off_d   = pattern_table_offset;
        sel_d   = ppu_ctrl1[4];
        state_d = S_NT;
      end
      S_NT: if (vram_ack) begin
        idx_d   = vram_data;
        state_d = nt_next;
      end
      S_AT: if (vram_ack) begin
        attr_d  = at_sel;
        state_d = S_PLO;
      end
      S_PLO: if (vram_ack) begin
        lo_d    = vram_data;
        state_d = S_PHI;
      end
      S_PHI: if (vram_ack) begin
        hi_d    = vram_data;
        state_d = S_OUT;
      end
      S_OUT: if (tile_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any fetch in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      off_q   <= '0;
      sel_q   <= 1'b0;
      idx_q   <= '0;
      attr_q  <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      off_q   <= off_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      attr_q  <= attr_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

  assign tile_pattern_lo = lo_q;
  assign tile_pattern_hi = hi_q;
  assign tile_attr       = attr_q;

endmodule

// File: tb/tb_ppu_bg_tile_fetcher.sv
// tb_ppu_bg_tile_fetcher: directed table-driven bench for the background tile fetcher
module tb_ppu_bg_tile_fetcher;

`ifdef PPU_BGF_ATTR_EN
  localparam bit ATTR = 1'b1;
`else
  localparam bit ATTR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_start = 1'b0;
  logic        fetch_ready;
  logic [15:0] nametable_ptr = '0;
  logic [2:0]  pattern_table_offset = '0;
  logic [7:0]  ppu_ctrl1 = '0;
  logic [13:0] vram_addr;
  logic        vram_rd;
  logic        vram_ack = 1'b0;
  logic [7:0]  vram_data = '0;
  logic        tile_valid;
  logic        tile_ready = 1'b0;
  logic [7:0]  tile_pattern_lo;
  logic [7:0]  tile_pattern_hi;
  logic [1:0]  tile_attr;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [15:0] ptr;
    logic [2:0]  off;
    logic [7:0]  ctrl;
    logic [7:0]  nt, at, lo, hi;
    logic [13:0] a_nt, a_at, a_plo, a_phi;
    logic [1:0]  attr;
    int          delay;
    int          hold;
  } vec_t;

  vec_t vecs[6];

  ppu_bg_tile_fetcher dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .fetch_start          (fetch_start),
    .fetch_ready          (fetch_ready),
    .nametable_ptr        (nametable_ptr),
    .pattern_table_offset (pattern_table_offset),
    .ppu_ctrl1            (ppu_ctrl1),
    .vram_addr            (vram_addr),
    .vram_rd              (vram_rd),
    .vram_ack             (vram_ack),
    .vram_data            (vram_data),
    .tile_valid           (tile_valid),
    .tile_ready           (tile_ready),
    .tile_pattern_lo      (tile_pattern_lo),
    .tile_pattern_hi      (tile_pattern_hi),
    .tile_attr            (tile_attr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input vec_t v);
    logic [13:0] exp_a[$];
    logic [7:0]  dat[$];
    logic [13:0] hold_a;
    int n, k, w;
    exp_a = {v.a_nt};
    dat   = {v.nt};
    if (ATTR) begin
      exp_a.push_back(v.a_at);
      dat.push_back(v.at);
    end
    exp_a.push_back(v.a_plo);
    dat.push_back(v.lo);
    exp_a.push_back(v.a_phi);
    dat.push_back(v.hi);
    hold_a = '0;
    chk("ready_idle", 32'(fetch_ready), 32'd1);
    nametable_ptr        = v.ptr;
    pattern_table_offset = v.off;
    ppu_ctrl1            = v.ctrl;
    fetch_start          = 1'b1;
    tick();
    fetch_start          = 1'b0;
    nametable_ptr        = ~v.ptr;
    pattern_table_offset = ~v.off;
    ppu_ctrl1            = ~v.ctrl;
    n = 1;
    k = 0;
    w = 0;
    while (!tile_valid && n < 200) begin
      if (w > 0) chk("rd_hold", 32'(vram_rd), 32'd1);
      if (vram_rd) begin
        if (w == 0) hold_a = vram_addr;
        else chk("addr_hold", 32'(vram_addr), 32'(hold_a));
        if (w == v.delay) begin
          chk("addr", 32'(vram_addr), k < exp_a.size() ? 32'(exp_a[k]) : 32'h3FFF);
          vram_ack  = 1'b1;
          vram_data = k < dat.size() ? dat[k] : 8'h00;
          k++;
          w = 0;
        end else w++;
      end
      tick();
      vram_ack  = 1'b0;
      vram_data = 8'($urandom);
      n++;
    end
    chk("tv_cycle", 32'(n), 32'((ATTR ? 5 : 4) + (ATTR ? 4 : 3) * v.delay));
    chk("reads", 32'(k), 32'(exp_a.size()));
    chk("lo", 32'(tile_pattern_lo), 32'(v.lo));
    chk("hi", 32'(tile_pattern_hi), 32'(v.hi));
    chk("attr", 32'(tile_attr), ATTR ? 32'(v.attr) : 32'd0);
    chk("rd_out", 32'(vram_rd), 32'd0);
    for (int i = 0; i < v.hold; i++) begin
      fetch_start = (i == 3);
      vram_ack    = (i == 5);
      tick();
      chk("hold_valid", 32'(tile_valid), 32'd1);
      chk("hold_ready", 32'(fetch_ready), 32'd0);
      chk("hold_lo", 32'(tile_pattern_lo), 32'(v.lo));
      chk("hold_hi", 32'(tile_pattern_hi), 32'(v.hi));
      chk("hold_attr", 32'(tile_attr), ATTR ? 32'(v.attr) : 32'd0);
    end
    fetch_start = 1'b0;
    vram_ack    = 1'b0;
    tile_ready  = 1'b1;
    tick();
    tile_ready  = 1'b0;
    chk("out_exit", 32'(tile_valid), 32'd0);
    chk("ready_back", 32'(fetch_ready), 32'd1);
    tick();
    chk("no_queued", 32'(vram_rd), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tvq[$];
    int ntq[$];
    int n;
    logic rd_prev;
    vecs[0] = '{16'h2462, 3'd5, 8'h10, 8'h5A, 8'hC0, 8'hA5, 8'h3C, 14'h2462, 14'h27C0, 14'h15A5, 14'h15AD, 2'd3, 0, 0};
    vecs[1] = '{16'h2462, 3'd5, 8'h10, 8'h5A, 8'hC0, 8'h81, 8'h7E, 14'h2462, 14'h27C0, 14'h15A5, 14'h15AD, 2'd3, 3, 0};
    vecs[2] = '{16'h2462, 3'd5, 8'h10, 8'h5A, 8'hC0, 8'h66, 8'h99, 14'h2462, 14'h27C0, 14'h15A5, 14'h15AD, 2'd3, 0, 10};
    vecs[3] = '{16'h2000, 3'd0, 8'h00, 8'h01, 8'h1B, 8'hF0, 8'h0F, 14'h2000, 14'h23C0, 14'h0010, 14'h0018, 2'd3, 0, 0};
    vecs[4] = '{16'h2BDF, 3'd7, 8'hEF, 8'hFF, 8'h96, 8'h5C, 8'hC5, 14'h2BDF, 14'h2BFF, 14'h0FF7, 14'h0FFF, 2'd2, 1, 2};
    vecs[5] = '{16'h2041, 3'd2, 8'h10, 8'h80, 8'h20, 8'h11, 8'h22, 14'h2041, 14'h23C0, 14'h1802, 14'h180A, 2'd2, 0, 0};

    repeat (3) tick();
    chk("rst_ready", 32'(fetch_ready), 32'd1);
    chk("rst_rd", 32'(vram_rd), 32'd0);
    chk("rst_addr", 32'(vram_addr), 32'd0);
    chk("rst_valid", 32'(tile_valid), 32'd0);
    chk("rst_lo", 32'(tile_pattern_lo), 32'd0);
    chk("rst_hi", 32'(tile_pattern_hi), 32'd0);
    chk("rst_attr", 32'(tile_attr), 32'd0);
    rst_n = 1'b1;
    tick();

    vram_ack  = 1'b1;
    vram_data = 8'hEE;
    repeat (2) tick();
    vram_ack  = 1'b0;
    chk("stray_ack_ready", 32'(fetch_ready), 32'd1);
    chk("stray_ack_rd", 32'(vram_rd), 32'd0);

    for (int i = 0; i < 6; i++) do_fetch(vecs[i]);

    nametable_ptr        = vecs[0].ptr;
    pattern_table_offset = vecs[0].off;
    ppu_ctrl1            = vecs[0].ctrl;
    fetch_start          = 1'b1;
    tick();
    fetch_start = 1'b0;
    vram_ack    = 1'b1;
    vram_data   = vecs[0].nt;
    tick();
    if (ATTR) begin
      vram_data = vecs[0].at;
      tick();
    end
    vram_ack = 1'b0;
    chk("plo_rd", 32'(vram_rd), 32'd1);
    chk("plo_addr", 32'(vram_addr), 32'h15A5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rd", 32'(vram_rd), 32'd0);
    chk("arst_addr", 32'(vram_addr), 32'd0);
    chk("arst_valid", 32'(tile_valid), 32'd0);
    chk("arst_lo", 32'(tile_pattern_lo), 32'd0);
    chk("arst_hi", 32'(tile_pattern_hi), 32'd0);
    chk("arst_attr", 32'(tile_attr), 32'd0);
    chk("arst_ready", 32'(fetch_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    do_fetch(vecs[4]);

    nametable_ptr        = vecs[0].ptr;
    pattern_table_offset = vecs[0].off;
    ppu_ctrl1            = vecs[0].ctrl;
    tile_ready           = 1'b1;
    fetch_start          = 1'b1;
    rd_prev              = 1'b0;
    n                    = 0;
    while (tvq.size() < 3 && n < 200) begin
      tick();
      n++;
      vram_ack  = vram_rd;
      vram_data = 8'h33;
      if (tile_valid) tvq.push_back(n);
      if (vram_rd && !rd_prev && vram_addr == 14'h2462) ntq.push_back(n);
      rd_prev = vram_rd;
    end
    fetch_start = 1'b0;
    vram_ack    = 1'b0;
    tick();
    tile_ready = 1'b0;
    chk("b2b_tiles", 32'(tvq.size()), 32'd3);
    chk("b2b_starts", 32'(ntq.size()), 32'd3);
    if (tvq.size() == 3 && ntq.size() == 3) begin
      chk("b2b_first", 32'(tvq[0] - ntq[0]), ATTR ? 32'd4 : 32'd3);
      chk("b2b_gap0", 32'(ntq[1] - tvq[0]), 32'd2);
      chk("b2b_gap1", 32'(ntq[2] - tvq[1]), 32'd2);
      chk("b2b_period", 32'(tvq[2] - tvq[1]), ATTR ? 32'd6 : 32'd5);
    end
    tick();
    chk("b2b_idle", 32'(fetch_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ppu_bg_tile_fetcher.md
PPU_BG_TILE_FETCHER -- requirements
Module: ppu_bg_tile_fetcher

Interface
REQ-001 SHALL have these ports (clock and reset first):
- clk  in  1  PPU clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- fetch_start  in  1  request to fetch one background tile
- fetch_ready  out  1  high when a request can be accepted
- nametable_ptr  in  16  nametable byte address, 0x2000-0x2FFF
- pattern_table_offset  in  3  fine row within tile
- ppu_ctrl1  in  8  PPU control register; bit 4 selects pattern table 0x0000/0x1000
- vram_addr  out  14  PPU memory read address
- vram_rd  out  1  read request, held until acked
- vram_ack  in  1  read complete; vram_data valid this cycle
- vram_data  in  8  read data
- tile_valid  out  1  fetched tile available
- tile_ready  in  1  downstream consumes tile
- tile_pattern_lo  out  8  pattern plane 0 row
- tile_pattern_hi  out  8  pattern plane 1 row
- tile_attr  out  2  palette select for this tile

Function
REQ-002 SHALL accept a request when fetch_start and fetch_ready are both high, latching nametable_ptr, pattern_table_offset and ppu_ctrl1[4] that cycle.
REQ-003 SHALL drive fetch_ready high only in IDLE.
REQ-004 SHALL use FSM states IDLE -> FETCH_NT -> FETCH_AT -> FETCH_PLO -> FETCH_PHI -> OUT -> IDLE; each FETCH state advances only on the cycle vram_ack is high.
REQ-005 SHALL assert vram_rd throughout each FETCH state and hold vram_addr stable until vram_ack; vram_rd SHALL be low in IDLE and OUT.
REQ-006 FETCH_NT address SHALL be nametable_ptr[13:0]; the returned byte is the tile index.
REQ-007 FETCH_AT address SHALL be 0x23C0 | (ptr & 0x0C00) | ((ptr >> 4) & 0x38) | ((ptr >> 2) & 0x07).
REQ-008 tile_attr SHALL be attribute byte bits [2s+1:2s], where s = {ptr[6], ptr[1]}.
REQ-009 FETCH_PLO address SHALL be {ctrl1[4], tile_index, 1'b0, offset}; FETCH_PHI address SHALL be identical with bit 3 set.
REQ-010 With single-cycle acks, tile_valid SHALL rise 5 cycles after the accepting edge.
REQ-011 In OUT, tile_valid SHALL be high and the tile outputs stable until tile_ready is high; the FSM SHALL then return to IDLE.
REQ-012 fetch_start SHALL be ignored while fetch_ready is low; no request is queued.
REQ-013 vram_ack outside a FETCH state SHALL be ignored.
REQ-014 Input changes after acceptance SHALL not affect the fetch in progress.

Reset
REQ-015 Asserting rst_n low SHALL immediately force IDLE, with vram_rd=0, vram_addr=0, tile_valid=0, tile_pattern_lo/hi=0, tile_attr=0 and fetch_ready=1 after release; this SHALL hold mid-fetch and abandon any outstanding read.

Configuration
REQ-016 With macro PPU_BGF_ATTR_EN defined, the block SHALL perform FETCH_AT as specified.
REQ-017 Without PPU_BGF_ATTR_EN, the block SHALL skip FETCH_AT (FETCH_NT -> FETCH_PLO), hold tile_attr at 0, and raise tile_valid 4 cycles after acceptance with single-cycle acks.

Structure
REQ-018 FSM state encoding, base addresses 0x23C0 and 0x2000, and the attribute-address function SHALL live in shared package ppu_pkg.
REQ-019 Attribute address and quadrant-select logic SHALL be a combinational sub-module ppu_attr_addr; everything else is a single module.

Verification
REQ-020 The bench SHALL cover the following scenarios:
- ptr=0x2462, offset=5, ctrl1=0x10, single-cycle acks returning NT=0x5A and AT=0xC0 -> address sequence 0x2462, 0x27C0, 0x15A5, 0x15AD; tile_attr=3; tile_valid rises at cycle 5.
- Same as the previous scenario, but with 3-cycle ack delay on every read -> vram_addr stable and vram_rd high across each wait; same results; no extra reads.
- tile_ready held low for 10 cycles in OUT with fetch_start pulsed -> outputs stable; fetch_ready=0; pulse dropped.
- rst_n asserted during FETCH_PLO -> vram_rd falls asynchronously; all outputs 0; the next request fetches cleanly.
- Build without PPU_BGF_ATTR_EN, ptr=0x2000, offset=0, ctrl1=0x00, NT=0x01 -> addresses 0x2000, 0x0010, 0x0018 only; tile_attr=0; tile_valid at cycle 4.
- Back-to-back requests with tile_ready tied high -> each accepted one cycle after the previous OUT.
